// File: rtl/lamp_pkg.sv
// Shared constants for the lamp PWM block: system clock, tick rate and frame length.
package lamp_pkg;

  localparam int c_sys_freq    = 100000000;
  localparam int c_tick_hz     = 2000000;
  localparam int c_frame_ticks = 16666;

  // Bits needed to hold any duty from 0 up to a full frame.
  function automatic int duty_width(input int frame_ticks);
    return $clog2(frame_ticks + 1);
  endfunction

endpackage

// File: rtl/lamp_pwm_tick_gen.sv
// Prescaler producing a one-cycle tick enable every c_div enabled system clocks.
module tick_gen
  import lamp_pkg::*;
#(
  parameter int c_div = c_sys_freq / c_tick_hz
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int              c_pw   = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(c_div - 1);

  logic [c_pw-1:0] pre;
  logic            at_last;

  assign at_last = (pre == c_last);
  assign o_tick  = i_enable && at_last;

  // Disable parks the prescaler at 0 so the first tick after re-enable is c_div cycles out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre <= '0;
    end else if (!i_enable || at_last) begin
      pre <= '0;
    end else begin
      pre <= pre + c_pw'(1);
    end
  end

endmodule

// File: rtl/lamp_pwm.sv
// Frame-synchronous multi-channel PWM: duties are double-buffered and only take effect at frame wrap.
module lamp_pwm
  import lamp_pkg::*;
#(
  parameter int c_freq     = c_sys_freq,
  parameter int c_tick_hz  = lamp_pkg::c_tick_hz,
  parameter int c_period   = c_frame_ticks,
  parameter int c_channels = 3,
  parameter int c_width    = duty_width(c_frame_ticks)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [c_channels*c_width-1:0] i_duty,
  input  logic                          i_load,
  output logic                          o_pending,
  output logic [c_width-1:0]            o_count,
  output logic                          o_frame,
  output logic [c_channels-1:0]         o_pwm
);

  localparam int                 c_div  = c_freq / c_tick_hz;
  localparam logic [c_width-1:0] c_last = c_width'(c_period - 1);

  logic                          tick;
  logic                          wrap;
  logic                          apply;
  logic [c_width-1:0]            count;
  logic [c_channels*c_width-1:0] shadow;
  logic [c_channels*c_width-1:0] active;
  logic                          pending;
  logic [c_channels-1:0]         level_p0;
  logic [c_channels-1:0]         pwm_p1;
  logic                          frame_p1;

  // Count never exceeds c_period-1, so any duty >= c_period saturates to constant high.
  function automatic logic duty_on(input logic [c_width-1:0] pos,
                                   input logic [c_width-1:0] duty);
    return (pos < duty);
  endfunction

  tick_gen #(
    .c_div (c_div)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  assign wrap  = tick && (count == c_last);
  assign apply = pending && (wrap || !i_enable);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (!i_enable) begin
      count <= '0;
    end else if (tick) begin
      count <= wrap ? '0 : count + c_width'(1);
    end
  end

  // A load on the apply edge still lands in shadow and stays pending for the next wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        active <= shadow;
      end
      if (i_load) begin
        shadow  <= i_duty;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Stage 0: per-channel compare of the live count against the applied duty
  always_comb begin
    level_p0 = '0;
    for (int n = 0; n < c_channels; n++) begin
      level_p0[n] = duty_on(count, active[n*c_width +: c_width]);
    end
  end

  // Stage 1: registered outputs, one cycle behind count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_p1   <= '0;
      frame_p1 <= 1'b0;
    end else begin
      pwm_p1   <= i_enable ? level_p0 : '0;
      frame_p1 <= wrap;
    end
  end

  assign o_pwm     = pwm_p1;
  assign o_frame   = frame_p1;
  assign o_count   = count;
  assign o_pending = pending;

endmodule

// File: tb/tb_lamp_pwm.sv
// Randomised and directed bench for lamp_pwm against a frame-level reference model.
module tb_lamp_pwm;

  localparam int c_freq      = 8;
  localparam int c_tick_hz   = 2;
  localparam int c_period    = 5;
  localparam int c_channels  = 3;
  localparam int c_width     = 3;
  localparam int c_div       = c_freq / c_tick_hz;
  localparam int c_frame_cyc = c_div * c_period;

  logic                          i_clk = 1'b0;
  logic                          i_rst_n;
  logic                          i_enable;
  logic                          i_load;
  logic [c_channels*c_width-1:0] i_duty;
  logic                          o_pending;
  logic [c_width-1:0]            o_count;
  logic                          o_frame;
  logic [c_channels-1:0]         o_pwm;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: enabled cycles since enable (count/frame derive from it), duty buffers, registered pwm.
  int                    m_n;
  int                    m_shadow [c_channels];
  int                    m_active [c_channels];
  logic                  m_pending;
  logic                  m_frame;
  logic [c_channels-1:0] m_pwm;

  lamp_pwm #(
    .c_freq     (c_freq),
    .c_tick_hz  (c_tick_hz),
    .c_period   (c_period),
    .c_channels (c_channels),
    .c_width    (c_width)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_enable  (i_enable),
    .i_duty    (i_duty),
    .i_load    (i_load),
    .o_pending (o_pending),
    .o_count   (o_count),
    .o_frame   (o_frame),
    .o_pwm     (o_pwm)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_vec();
    int cnt;
    cnt = (m_n / c_div) % c_period;
    return {m_pwm, 3'(cnt), m_frame, m_pending};
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < c_channels; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    m_pending = 1'b0;
    m_frame   = 1'b0;
    m_pwm     = '0;
  endtask

  // One clock: model advanced from pre-edge inputs, returns 2 time units after the edge.
  task automatic step();
    int                    cnt;
    logic                  wrap;
    logic                  apply;
    logic                  en;
    logic                  ld;
    logic [c_channels-1:0] npwm;
    logic [c_channels*c_width-1:0] d;
    en   = i_enable;
    ld   = i_load;
    d    = i_duty;
    cnt  = (m_n / c_div) % c_period;
    wrap = en && ((m_n % c_frame_cyc) == c_frame_cyc - 1);
    for (int c = 0; c < c_channels; c++) npwm[c] = en && (cnt < m_active[c]);
    apply = m_pending && (wrap || !en);
    @(posedge i_clk);
    m_pwm   = npwm;
    m_frame = wrap;
    if (apply) begin
      for (int c = 0; c < c_channels; c++) m_active[c] = m_shadow[c];
    end
    if (ld) begin
      for (int c = 0; c < c_channels; c++) m_shadow[c] = int'(d[c*c_width +: c_width]);
      m_pending = 1'b1;
    end else if (apply) begin
      m_pending = 1'b0;
    end
    m_n = en ? m_n + 1 : 0;
    #2;
  endtask

  task automatic set_duty(input int d2, input int d1, input int d0);
    i_duty = {3'(d2), 3'(d1), 3'(d0)};
  endtask

  task automatic pulse_load(input int d2, input int d1, input int d0);
    set_duty(d2, d1, d0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic collect(input int cycles, output int hi0, output int hi1, output int hi2);
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      hi0 += int'(o_pwm[0]);
      hi1 += int'(o_pwm[1]);
      hi2 += int'(o_pwm[2]);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_enable = 1'b0; i_load = 1'b0; i_duty = '0;
    #1 i_rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({o_pwm, o_count, o_frame, o_pending} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_initial: got %b want 00000000", {o_pwm, o_count, o_frame, o_pending});
    end
    #1 i_rst_n = 1'b1;
    i_enable = 1'b1;
    pulse_load(5, 5, 5);
    for (int k = 0; k < 27; k++) step();
    pulse_load(6, 1, 3);
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if ({o_pwm, o_count, o_frame, o_pending} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_prerun: got %b want %b", {o_pwm, o_count, o_frame, o_pending}, model_vec());
      end
    end
    #3 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_pwm, o_count, o_frame, o_pending} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 00000000", {o_pwm, o_count, o_frame, o_pending});
    end
    model_reset();
    i_enable = 1'b0;
    #1 i_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if ({o_pwm, o_count, o_frame, o_pending} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_idle: got %b want %b", {o_pwm, o_count, o_frame, o_pending}, model_vec());
      end
    end
  endtask

  task automatic test_free_run();
    int frames;
    frames = 0;
    i_enable = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      frames += int'(o_frame);
      n_tests++;
      if ({o_pwm, o_count, o_frame, o_pending} !== model_vec()) begin
        n_fail++;
        $display("FAIL free_run cyc %0d: got %b want %b", k, {o_pwm, o_count, o_frame, o_pending}, model_vec());
      end
    end
    n_tests++;
    if (frames !== 2) begin
      n_fail++;
      $display("FAIL free_run_frames: got %0d want 2", frames);
    end
  endtask

  task automatic test_load_apply();
    int  hi0, hi1, hi2;
    logic found;
    pulse_load(7, 2, 0);
    n_tests++;
    if (o_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL load_pending: got %b want 1", o_pending);
    end
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_frame) begin found = 1'b1; break; end
      step();
      n_tests++;
      if ({o_pwm, o_count, o_frame, o_pending} !== model_vec()) begin
        n_fail++;
        $display("FAIL load_wait: got %b want %b", {o_pwm, o_count, o_frame, o_pending}, model_vec());
      end
    end
    n_tests++;
    if (found !== 1'b1 || o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wrap: frame_seen %b pending %b want 1 0", found, o_pending);
    end
    collect(c_frame_cyc, hi0, hi1, hi2);
    n_tests++;
    if (hi0 !== 0 || hi1 !== 8 || hi2 !== 20) begin
      n_fail++;
      $display("FAIL load_high_time: got %0d/%0d/%0d want 0/8/20", hi0, hi1, hi2);
    end
  endtask

  task automatic test_overwrite();
    int  hi0, hi1, hi2;
    logic found;
    pulse_load(1, 1, 1);
    step();
    step();
    pulse_load(3, 3, 3);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_frame) begin found = 1'b1; break; end
      step();
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL overwrite_frame: got %b want 1", found);
    end
    collect(c_frame_cyc, hi0, hi1, hi2);
    n_tests++;
    if (hi0 !== 12 || hi1 !== 12 || hi2 !== 12) begin
      n_fail++;
      $display("FAIL overwrite_high_time: got %0d/%0d/%0d want 12/12/12", hi0, hi1, hi2);
    end
  endtask

  task automatic test_load_on_wrap();
    int hi0, hi1, hi2;
    pulse_load(2, 2, 2);
    for (int k = 0; k < 25 && (m_n % c_frame_cyc) != c_frame_cyc - 1; k++) step();
    pulse_load(4, 4, 4);
    n_tests++;
    if (o_frame !== 1'b1 || o_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load_state: frame %b pending %b want 1 1", o_frame, o_pending);
    end
    collect(c_frame_cyc, hi0, hi1, hi2);
    n_tests++;
    if (hi0 !== 8 || hi1 !== 8 || hi2 !== 8 || o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_load_first: got %0d/%0d/%0d pend %b want 8/8/8 pend 0", hi0, hi1, hi2, o_pending);
    end
    collect(c_frame_cyc, hi0, hi1, hi2);
    n_tests++;
    if (hi0 !== 16 || hi1 !== 16 || hi2 !== 16) begin
      n_fail++;
      $display("FAIL wrap_load_second: got %0d/%0d/%0d want 16/16/16", hi0, hi1, hi2);
    end
  endtask

  task automatic test_disable();
    int hi0, hi1, hi2;
    int k;
    for (int j = 0; j < 6; j++) step();
    pulse_load(3, 1, 2);
    step();
    i_enable = 1'b0;
    step();
    n_tests++;
    if (o_count !== 3'd0 || o_pwm !== 3'b000 || o_pending !== 1'b0 || o_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_state: count %0d pwm %b pend %b frame %b want 0 000 0 0", o_count, o_pwm, o_pending, o_frame);
    end
    step();
    step();
    i_enable = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (o_count == 3'd0 && k < 10);
    n_tests++;
    if (k !== 4) begin
      n_fail++;
      $display("FAIL reenable_latency: got %0d cycles want 4", k);
    end
    collect(c_frame_cyc, hi0, hi1, hi2);
    n_tests++;
    if (hi0 !== 8 || hi1 !== 4 || hi2 !== 12) begin
      n_fail++;
      $display("FAIL disable_applied: got %0d/%0d/%0d want 8/4/12", hi0, hi1, hi2);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      i_enable = ($urandom_range(15) != 0);
      i_load   = ($urandom_range(7) == 0);
      i_duty   = 9'($urandom());
      step();
      n_tests++;
      if ({o_pwm, o_count, o_frame, o_pending} !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", k, {o_pwm, o_count, o_frame, o_pending}, model_vec());
      end
    end
    i_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_apply();
    test_overwrite();
    test_load_on_wrap();
    test_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
